coef_table_loader: RTL and testbench
====================================

COEF_TABLE_LOADER -- requirements
Module: coef_table_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, coefficient table address width.
REQ-002 SHALL have parameter DATA_W, default 48, coefficient word width: sine field [47:24], cos2 field [23:0].
REQ-003 SHALL have port Fg_clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle load request.
REQ-006 SHALL have port start_addr, input, ADDR_W, first table address written.
REQ-007 SHALL have port word_count, input, ADDR_W+1, number of words to load (0..2048).
REQ-008 SHALL have port in_data, input, 8, coefficient byte stream.
REQ-009 SHALL have port in_valid, input, 1, in_data valid.
REQ-010 SHALL have port in_ready, output, 1, byte accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port wr_en, output, 1, table RAM write strobe.
REQ-012 SHALL have port wr_addr, output, ADDR_W, table RAM write address.
REQ-013 SHALL have port wr_data, output, DATA_W, table RAM write data.
REQ-014 SHALL have port busy, output, 1, load in progress.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1, sticky error flag for the last load.

Function
REQ-017 SHALL use FSM states IDLE, COLLECT, WRITE, CHECK, FINISH.
REQ-018 IDLE: start=1 with word_count>0 -> latch start_addr and word_count, clear err, go to COLLECT; busy=1 from the next cycle.
REQ-019 IDLE: start=1 with word_count=0 -> FINISH with err=1 and no writes.
REQ-020 COLLECT: in_ready=1; accept 6 bytes MSB first: byte0 -> [47:40], byte5 -> [7:0]; in_valid gaps are allowed and hold state.
REQ-021 After the 6th byte is accepted -> WRITE; in_ready=0 in WRITE.
REQ-022 WRITE lasts exactly 1 cycle: wr_en=1, wr_addr=current address, wr_data=assembled word; then address+1, remaining-1.
REQ-023 Address SHALL wrap modulo 2^ADDR_W (2047 -> 0) without error.
REQ-024 After WRITE: remaining>0 -> COLLECT; remaining=0 -> CHECK if COEF_CHECKSUM_EN is defined, otherwise FINISH.
REQ-025 FINISH: done=1 for one cycle, busy=0, return to IDLE.
REQ-026 start asserted while busy SHALL be ignored and SHALL set err=1 without disturbing the load.
REQ-027 wr_en SHALL be 0 in every state except WRITE; wr_addr and wr_data hold their last values otherwise.
REQ-028 in_ready SHALL be 0 in IDLE, WRITE, and FINISH.
REQ-029 Throughput: maximum 1 word per 7 cycles.

Reset
REQ-030 Reset=1 at any clock edge SHALL force IDLE and discard any partial word and count.
REQ-031 Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
REQ-032 Reset mid-load SHALL produce no further wr_en and no done pulse.

Configuration
REQ-033 Macro COEF_CHECKSUM_EN defined: keep an 8-bit running sum (mod 256) of all accepted data bytes.
REQ-034 With COEF_CHECKSUM_EN, CHECK state: in_ready=1; accept one byte; err=1 if the byte does not equal the sum; then FINISH.
REQ-035 Macro COEF_CHECKSUM_EN undefined: no CHECK state and no sum logic; FINISH directly follows the last WRITE.

Verification
REQ-036 start_addr=0x010, word_count=1, bytes 12 34 56 78 9A BC -> one wr_en, wr_addr=0x010, wr_data=0x123456789ABC, done 1 cycle later, err=0.
REQ-037 start_addr=0x7FF, word_count=2, 12 bytes -> writes at 0x7FF then 0x000, err=0.
REQ-038 word_count=0 -> no wr_en, done pulse, err=1.
REQ-039 start pulsed during a 3-word load -> exactly 3 writes at original addresses, err=1.
REQ-040 Reset after byte 3 of word 2 -> only 1 write, busy=0 and no done; a new load then writes its first word correctly.
REQ-041 COEF_CHECKSUM_EN, bytes 01 02 03 04 05 06 + checksum 0x15 -> err=0; checksum 0x16 -> err=1.

Source files
------------

// File: rtl/coef_table_loader.sv
// coef_table_loader
// Streams 6-byte coefficient words (MSB first) from a byte interface into a
// coefficient table RAM: one write per assembled word, address auto-increment
// with modulo-2^ADDR_W wrap, busy/done/err status.
// Optional build macro COEF_CHECKSUM_EN: after the last word one extra byte is
// accepted and compared against the 8-bit running sum of all data bytes.
module coef_table_loader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 48
) (
    input  logic              Fg_clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   remaining_r;
    logic [2:0]        byte_cnt_r;
    logic [DATA_W-1:0] data_r;
    logic              in_ready_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              accept_s;
    logic              zero_count_s;
`ifdef COEF_CHECKSUM_EN
    logic [7:0]        sum_r;
`endif

    assign accept_s     = in_valid && in_ready_r;
    assign zero_count_s = (word_count == {(ADDR_W+1){1'b0}});

    assign in_ready = in_ready_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

    // Next-state decode of the load sequencer.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (zero_count_s) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s && (byte_cnt_r == 3'd5)) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = COLLECT;
                end
            end
            WRITE: begin
                if (remaining_r == {{ADDR_W{1'b0}}, 1'b1}) begin
`ifdef COEF_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = FINISH;
`endif
                end else begin
                    state_nxt = COLLECT;
                end
            end
            CHECK: begin
                if (accept_s) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = CHECK;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            in_ready_r <= (state_nxt == COLLECT) || (state_nxt == CHECK);
            wr_en_r    <= (state_nxt == WRITE);
            busy_r     <= (state_nxt == COLLECT) || (state_nxt == WRITE) ||
                          (state_nxt == CHECK);
            done_r     <= (state_nxt == FINISH);
        end
    end

    // Word assembly, address/count bookkeeping and RAM write port.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            addr_r      <= {ADDR_W{1'b0}};
            remaining_r <= {(ADDR_W+1){1'b0}};
            byte_cnt_r  <= 3'd0;
            data_r      <= {DATA_W{1'b0}};
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !zero_count_s) begin
                        addr_r      <= start_addr;
                        remaining_r <= word_count;
                        byte_cnt_r  <= 3'd0;
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                COLLECT: begin
                    if (accept_s) begin
                        data_r <= {data_r[DATA_W-9:0], in_data};
                        if (byte_cnt_r == 3'd5) begin
                            byte_cnt_r <= 3'd0;
                            wr_addr_r  <= addr_r;
                            wr_data_r  <= {data_r[DATA_W-9:0], in_data};
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 3'd1;
                        end
                    end else begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                end
                WRITE: begin
                    // Natural overflow of addr_r gives the modulo wrap.
                    addr_r      <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    remaining_r <= remaining_r - {{ADDR_W{1'b0}}, 1'b1};
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

`ifdef COEF_CHECKSUM_EN
    // Running modulo-256 sum of every accepted data byte of the current load.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            sum_r <= 8'd0;
        end else if ((state_r == IDLE) && start) begin
            sum_r <= 8'd0;
        end else if ((state_r == COLLECT) && accept_s) begin
            sum_r <= sum_r + in_data;
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    // Sticky error: cleared by a valid start, set by empty load, start while busy or bad checksum.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            err_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            err_r <= zero_count_s;
        end else if (busy_r && start) begin
            err_r <= 1'b1;
`ifdef COEF_CHECKSUM_EN
        end else if ((state_r == CHECK) && accept_s && (in_data != sum_r)) begin
            err_r <= 1'b1;
`endif
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_coef_table_loader.sv
// Self-checking bench for coef_table_loader: table of single-word loads plus
// hand-written sequences for wrap, start-while-busy and reset mid-load.
// With COEF_CHECKSUM_EN defined the bench appends checksum bytes and runs the
// checksum pass/fail sequence as well.
module tb_coef_table_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] start_addr;
    logic [11:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [47:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    coef_table_loader #(.ADDR_W(11), .DATA_W(48)) dut (
        .Fg_clk    (clk),
        .Reset     (rst),
        .start     (start),
        .start_addr(start_addr),
        .word_count(word_count),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed writes and done pulses, sampled on the falling edge.
    logic [10:0] wa[$];
    logic [47:0] wd[$];
    int          wcyc[$];
    int          cyc      = 0;
    int          done_cnt = 0;
    int          done_base;
    logic        done_err;
    logic        done_busy;
    logic [7:0]  tb_sum;

    always @(negedge clk) begin
        cyc++;
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wcyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_err  = err;
            done_busy = busy;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] get_addr(input int k);
        if (wa.size() > k) return {53'd0, wa[k]};
        else return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] get_data(input int k);
        if (wd.size() > k) return {16'd0, wd[k]};
        else return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
        tb_sum   = tb_sum + b;
    endtask

    task automatic send_word(input logic [47:0] w, input int gap);
        for (int i = 0; i < 6; i++) begin
            send_byte(w[47-8*i -: 8], gap);
        end
    endtask

    task automatic finish_load();
`ifdef COEF_CHECKSUM_EN
        logic [7:0] s;
        s = tb_sum;
        send_byte(s, 0);
`endif
    endtask

    task automatic do_load(input logic [10:0] a, input logic [11:0] c);
        wa.delete();
        wd.delete();
        wcyc.delete();
        done_base  = done_cnt;
        tb_sum     = 8'd0;
        start      = 1'b1;
        start_addr = a;
        word_count = c;
        tick();
        start      = 1'b0;
        start_addr = 11'h555;
        word_count = 12'd7;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_done_timeout: got none expected done", name);
        end
        repeat (3) tick();
        check({name, "_done_pulses"}, done_cnt - done_base, 1);
        check({name, "_busy_at_done"}, {63'd0, done_busy}, 0);
    endtask

    typedef struct {
        string       name;
        logic [10:0] addr;
        logic [11:0] count;
        logic [47:0] stream;
        int          gap;
        int          exp_writes;
        logic [10:0] exp_addr;
        logic [47:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic",     11'h010, 12'd1, 48'h12_34_56_78_9A_BC, 0, 1, 11'h010, 48'h123456789ABC, 1'b0};
        vecs[1] = '{"zero_cnt",  11'h123, 12'd0, 48'h0,                 0, 0, 11'h000, 48'h0,            1'b1};
        vecs[2] = '{"err_clear", 11'h3A5, 12'd1, 48'hFF_EE_DD_CC_BB_AA, 2, 1, 11'h3A5, 48'hFFEEDDCCBBAA, 1'b0};
        vecs[3] = '{"top_addr",  11'h7FF, 12'd1, 48'h00_FF_00_FF_00_FF, 1, 1, 11'h7FF, 48'h00FF00FF00FF, 1'b0};
        vecs[4] = '{"low_addr",  11'h000, 12'd1, 48'h80_00_00_00_00_01, 0, 1, 11'h000, 48'h800000000001, 1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 11'h0;
        word_count = 12'd0;
        in_data    = 8'h0;
        in_valid   = 1'b0;
        tb_sum     = 8'd0;
        repeat (3) tick();
        check("rst_in_ready", {63'd0, in_ready}, 0);
        check("rst_wr_en",    {63'd0, wr_en}, 0);
        check("rst_wr_addr",  {53'd0, wr_addr}, 0);
        check("rst_wr_data",  {16'd0, wr_data}, 0);
        check("rst_busy_done_err", {61'd0, busy, done, err}, 0);
        rst = 1'b0;
        tick();

        // Table-driven single-word loads.
        for (int i = 0; i < 5; i++) begin
            do_load(vecs[i].addr, vecs[i].count);
            if (vecs[i].count != 12'd0) begin
                check({vecs[i].name, "_busy"}, {63'd0, busy}, 1);
                send_word(vecs[i].stream, vecs[i].gap);
                finish_load();
            end
            wait_done(vecs[i].name);
            check({vecs[i].name, "_writes"}, wa.size(), vecs[i].exp_writes);
            if (vecs[i].exp_writes > 0) begin
                check({vecs[i].name, "_addr"}, get_addr(0), {53'd0, vecs[i].exp_addr});
                check({vecs[i].name, "_data"}, get_data(0), {16'd0, vecs[i].exp_data});
            end
            check({vecs[i].name, "_err"}, {63'd0, done_err}, {63'd0, vecs[i].exp_err});
        end

        // Two words across the top of the address space, back to back.
        do_load(11'h7FF, 12'd2);
        send_word(48'hAABBCCDDEEFF, 0);
        send_word(48'h010203040506, 0);
        finish_load();
        wait_done("wrap");
        check("wrap_writes", wa.size(), 2);
        check("wrap_addr0", get_addr(0), 64'h7FF);
        check("wrap_addr1", get_addr(1), 64'h000);
        check("wrap_data0", get_data(0), 64'hAABBCCDDEEFF);
        check("wrap_data1", get_data(1), 64'h010203040506);
        if (wcyc.size() == 2) check("wrap_spacing", wcyc[1] - wcyc[0], 7);
        else check("wrap_spacing_cnt", wcyc.size(), 2);
        check("wrap_err", {63'd0, done_err}, 0);

        // Start pulsed mid-load must not disturb the three-word load.
        do_load(11'h100, 12'd3);
        send_word(48'h111111111111, 0);
        start      = 1'b1;
        start_addr = 11'h555;
        word_count = 12'd5;
        tick();
        start = 1'b0;
        send_word(48'h222222222222, 0);
        send_word(48'h333333333333, 0);
        finish_load();
        wait_done("busy_start");
        check("busy_start_writes", wa.size(), 3);
        check("busy_start_addr0", get_addr(0), 64'h100);
        check("busy_start_addr1", get_addr(1), 64'h101);
        check("busy_start_addr2", get_addr(2), 64'h102);
        check("busy_start_data2", get_data(2), 64'h333333333333);
        check("busy_start_err", {63'd0, done_err}, 1);

        // Reset after byte 3 of word 2, then a fresh load.
        do_load(11'h020, 12'd3);
        send_word(48'hCAFEBABE0001, 0);
        send_byte(8'h5A, 0);
        send_byte(8'h5B, 0);
        send_byte(8'h5C, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {63'd0, busy}, 0);
        check("rst_mid_in_ready", {63'd0, in_ready}, 0);
        repeat (10) tick();
        check("rst_mid_writes", wa.size(), 1);
        check("rst_mid_no_done", done_cnt - done_base, 0);
        do_load(11'h040, 12'd1);
        send_word(48'hA1B2C3D4E5F6, 0);
        finish_load();
        wait_done("after_rst");
        check("after_rst_writes", wa.size(), 1);
        check("after_rst_addr", get_addr(0), 64'h040);
        check("after_rst_data", get_data(0), 64'hA1B2C3D4E5F6);
        check("after_rst_err", {63'd0, done_err}, 0);

`ifdef COEF_CHECKSUM_EN
        // Checksum byte: 01+02+..+06 = 0x15.
        do_load(11'h200, 12'd1);
        send_word(48'h010203040506, 0);
        send_byte(8'h15, 0);
        wait_done("csum_ok");
        check("csum_ok_err", {63'd0, done_err}, 0);
        do_load(11'h200, 12'd1);
        send_word(48'h010203040506, 0);
        send_byte(8'h16, 0);
        wait_done("csum_bad");
        check("csum_bad_err", {63'd0, done_err}, 1);
        check("csum_bad_data", get_data(0), 64'h010203040506);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
